// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon game input path: FSM encoding,
// one-hot button codes and the default debounce length.
package simon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  localparam logic [3:0] BTN0 = 4'b0001;
  localparam logic [3:0] BTN1 = 4'b0010;
  localparam logic [3:0] BTN2 = 4'b0100;
  localparam logic [3:0] BTN3 = 4'b1000;

  // 20 ms at 50 MHz
  localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

  function automatic logic is_one_hot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer bringing the raw push buttons into the clk_50M domain.
module btn_sync (
  input  logic       clk_50M,
  input  logic       reset,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta;

  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_input.sv
// Debounces the four game buttons, emitting one press pulse per accepted
// single-button press and rejecting simultaneous multi-button presses.
//
//   state       | meaning
//   ST_IDLE     | waiting for an enabled, non-zero button sample
//   ST_DEBOUNCE | sample must stay stable for DEBOUNCE_CYCLES
//   ST_HELD     | accepted button held, shown on display_bits
//   ST_RELEASE  | buttons must read zero for DEBOUNCE_CYCLES
module button_input
  import simon_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic       clk_50M,
  input  logic       reset,
  input  logic [3:0] btn,
  input  logic       enable,
  output logic [3:0] press_code,
  output logic       press_valid,
  output logic [3:0] display_bits,
  output logic       multi_err
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] TC = CW'(DEBOUNCE_CYCLES - 1);

  state_t          state, state_next;
  logic [CW-1:0]   count, count_next;
  logic [3:0]      sample, sample_next;
  logic [3:0]      code_next, disp_next;
  logic            pv_next, err_next;
  logic [3:0]      sync;

  btn_sync u_sync (
    .clk_50M (clk_50M),
    .reset   (reset),
    .d       (btn),
    .q       (sync)
  );

  always_comb begin
    state_next  = state;
    count_next  = count;
    sample_next = sample;
    code_next   = press_code;
    pv_next     = 1'b0;
    err_next    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable && (sync != 4'd0)) begin
          sample_next = sync;
          count_next  = '0;
          state_next  = ST_DEBOUNCE;
        end
      end
      ST_DEBOUNCE: begin
        if ((sync != sample) || !enable) begin
          state_next = ST_IDLE;
        end else if (count == TC) begin
          count_next = '0;
          if (is_one_hot(sample)) begin
            code_next  = sample;
            pv_next    = 1'b1;
            state_next = ST_HELD;
          end else begin
            err_next   = 1'b1;
            state_next = ST_RELEASE;
          end
        end else begin
          count_next = count + CW'(1);
        end
      end
      ST_HELD: begin
        // extra buttons are ignored; only a full release leaves HELD
        if (sync == 4'd0) begin
          count_next = '0;
          state_next = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (sync != 4'd0) begin
          count_next = '0;
        end else if (count == TC) begin
          state_next = ST_IDLE;
        end else begin
          count_next = count + CW'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
    disp_next = (state_next == ST_HELD) ? code_next : 4'd0;
  end

  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      count        <= '0;
      sample       <= '0;
      press_code   <= '0;
      press_valid  <= 1'b0;
      display_bits <= '0;
      multi_err    <= 1'b0;
    end else begin
      state        <= state_next;
      count        <= count_next;
      sample       <= sample_next;
      press_code   <= code_next;
      press_valid  <= pv_next;
      display_bits <= disp_next;
      multi_err    <= err_next;
    end
  end

endmodule

// File: tb/tb_button_input.sv
// Scoreboard bench for button_input with a short debounce length: stimulus
// queues expected pulses, a negedge monitor pops and checks them.
module tb_button_input;
  import simon_pkg::*;

  localparam int N = 4;

  logic       clk_50M = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btn = 4'd0;
  logic       enable = 1'b0;
  logic [3:0] press_code;
  logic       press_valid;
  logic [3:0] display_bits;
  logic       multi_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    bit         err;
    logic [3:0] code;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  button_input #(.DEBOUNCE_CYCLES(N)) dut (
    .clk_50M      (clk_50M),
    .reset        (reset),
    .btn          (btn),
    .enable       (enable),
    .press_code   (press_code),
    .press_valid  (press_valid),
    .display_bits (display_bits),
    .multi_err    (multi_err)
  );

  always #5 clk_50M = ~clk_50M;

  always @(posedge clk_50M) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Inputs change 2 time units after a rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_50M);
      #2;
    end
  endtask

  task automatic push(input bit err, input logic [3:0] code, input int at);
    exp_t e;
    e.err  = err;
    e.code = code;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  always @(negedge clk_50M) begin
    if (!reset && (press_valid || multi_err)) begin
      chk("pv_err_exclusive", {31'd0, press_valid & multi_err}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got pv=%0b err=%0b at cycle %0d, required none",
                 press_valid, multi_err, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pulse_kind_err", {31'd0, multi_err}, {31'd0, mon_e.err});
        chk("pulse_cycle", cyc, mon_e.cyc);
        chk("pulse_press_code", {28'd0, press_code}, {28'd0, mon_e.code});
        chk("pulse_display_bits", {28'd0, display_bits},
            mon_e.err ? 32'd0 : {28'd0, mon_e.code});
      end
    end
  end

  initial begin
    int c;
    int d;
    int r;

    // reset state
    step(3);
    chk("rst_press_code", {28'd0, press_code}, 32'd0);
    chk("rst_display", {28'd0, display_bits}, 32'd0);
    chk("rst_press_valid", {31'd0, press_valid}, 32'd0);
    chk("rst_multi_err", {31'd0, multi_err}, 32'd0);
    reset = 1'b0;
    step(2);

    // single press: first sampling edge c+1, pulse after edge c+1+N+2
    enable = 1'b1;
    btn = BTN2;
    c = cyc;
    push(1'b0, BTN2, c + N + 3);
    step(20);
    chk("t1_display_held", {28'd0, display_bits}, {28'd0, BTN2});
    chk("t1_press_code", {28'd0, press_code}, {28'd0, BTN2});
    btn = 4'd0;
    step(15);
    chk("t1_display_released", {28'd0, display_bits}, 32'd0);

    // bounce: three 2-cycle highs never reach the terminal count
    for (int i = 0; i < 3; i++) begin
      btn = BTN2;
      step(2);
      btn = 4'd0;
      step(2);
    end
    btn = BTN2;
    c = cyc;
    push(1'b0, BTN2, c + N + 3);
    step(20);
    chk("t2_display_held", {28'd0, display_bits}, {28'd0, BTN2});
    btn = 4'd0;
    step(15);

    // multi-press rejected, press_code keeps BTN2
    btn = 4'b0011;
    c = cyc;
    push(1'b1, BTN2, c + N + 3);
    step(8);
    chk("t3_display_zero", {28'd0, display_bits}, 32'd0);
    step(2);
    btn = 4'd0;
    step(15);
    chk("t3_press_code_kept", {28'd0, press_code}, {28'd0, BTN2});

    // disabled: nothing accepted; enabling with sync already high
    enable = 1'b0;
    btn = BTN3;
    step(20);
    chk("t4_display_disabled", {28'd0, display_bits}, 32'd0);
    enable = 1'b1;
    c = cyc;
    push(1'b0, BTN3, c + N + 1);
    step(10);
    chk("t4_display_held", {28'd0, display_bits}, {28'd0, BTN3});
    enable = 1'b0;
    btn = 4'd0;
    step(15);
    chk("t4_display_released", {28'd0, display_bits}, 32'd0);

    // reset mid-debounce discards the press, then it is re-debounced
    enable = 1'b1;
    btn = BTN1;
    step(4);
    reset = 1'b1;
    #1;
    chk("t5_rst_press_code", {28'd0, press_code}, 32'd0);
    chk("t5_rst_display", {28'd0, display_bits}, 32'd0);
    chk("t5_rst_pv", {31'd0, press_valid}, 32'd0);
    step(3);
    reset = 1'b0;
    r = cyc;
    push(1'b0, BTN1, r + N + 3);
    step(12);
    chk("t5_press_code", {28'd0, press_code}, {28'd0, BTN1});
    btn = 4'd0;
    step(15);

    // release glitch restarts the release count; a press landing where an
    // unrestarted count would already be idle must be swallowed
    btn = BTN0;
    c = cyc;
    push(1'b0, BTN0, c + N + 3);
    step(12);
    btn = 4'd0;
    d = cyc;
    step(4);
    btn = BTN0;
    step(1);
    btn = 4'd0;
    step(2);
    chk("t6_glitch_timing", cyc, d + 7);
    btn = BTN1;
    step(10);
    chk("t6_display_release", {28'd0, display_bits}, 32'd0);
    btn = 4'd0;
    step(15);

    // recovery: a fresh press is accepted normally
    btn = BTN3;
    c = cyc;
    push(1'b0, BTN3, c + N + 3);
    step(12);
    chk("t7_display_held", {28'd0, display_bits}, {28'd0, BTN3});
    btn = 4'd0;
    step(20);

    chk("pending_expected", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
